// File: rtl/text_buffer_writer.sv
// Character-cell text buffer: interprets a byte stream and writes an 80x60 character RAM behind a cursor.
// Latency: a printable byte updates RAM and cursor on its accept edge; the read port has 1-cycle latency.
// Backpressure: in_ready is low during a full-screen clear and during a one-row blank after a row advance.
module text_buffer_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int CW   = 7,
    parameter int RW   = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_char,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_char,
    output logic [CW-1:0] cursor_col,
    output logic [RW-1:0] cursor_row,
    output logic          busy
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINECLR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt, row_inc;
    logic [AW-1:0] cur_base, cur_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_dat;
    logic [7:0]    mem [CELLS];
    logic          rd_oob;
    logic [AW-1:0] rd_addr;

    assign cur_base = AW'(cursor_row) * AW'(COLS);
    assign cur_addr = cur_base + AW'(cursor_col);
    assign row_inc  = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + 1'b1;
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        col_nxt   = cursor_col;
        row_nxt   = cursor_row;
        wr_en     = 1'b0;
        wr_addr   = cur_addr;
        wr_dat    = 8'h20;
        case (state)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                if (cnt == AW'(CELLS - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // cursor_row already points at the new row when this state is entered
            S_LINECLR: begin
                wr_en   = 1'b1;
                wr_addr = cur_base + cnt;
                if (cnt == AW'(COLS - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                        wr_en  = 1'b1;
                        wr_dat = in_char;
                        if (cursor_col == CW'(COLS - 1)) begin
                            col_nxt   = '0;
                            row_nxt   = row_inc;
                            state_nxt = S_LINECLR;
                            cnt_nxt   = '0;
                        end else begin
                            col_nxt = cursor_col + 1'b1;
                        end
                    end else begin
                        case (in_char)
                            8'h0A: begin
                                col_nxt   = '0;
                                row_nxt   = row_inc;
                                state_nxt = S_LINECLR;
                                cnt_nxt   = '0;
                            end
                            8'h0D: col_nxt = '0;
                            8'h08: begin
                                if (cursor_col != '0) begin
                                    col_nxt = cursor_col - 1'b1;
                                    wr_en   = 1'b1;
                                    wr_addr = cur_addr - 1'b1;
                                end
                            end
                            8'h0C: begin
                                col_nxt   = '0;
                                row_nxt   = '0;
                                state_nxt = S_CLEAR;
                                cnt_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Out-of-range cells are never indexed; they read as blank
    assign rd_oob  = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
    assign rd_addr = AW'(rd_row) * AW'(COLS) + AW'(rd_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_char <= 8'h20;
        end else if (rd_oob) begin
            rd_char <= 8'h20;
        end else begin
            rd_char <= mem[rd_addr];
        end
    end
endmodule
